// File: rtl/player_motion_ctrl_if.sv
// Keypad/tile-map inputs and renderer-facing outputs of the Pac-Man motion controller.
// master = keypad/map owner side, slave = the controller.
interface player_motion_ctrl_if #(
  parameter int TILE    = 20,
  parameter int COLS    = 32,
  parameter int ROWS    = 24,
  parameter int SCORE_W = 12
);
  localparam int XW = $clog2(COLS * TILE);
  localparam int YW = $clog2(ROWS * TILE);
  localparam int NT = ROWS * COLS;
  localparam int IW = $clog2(NT);

  logic          freeze;
  logic          w;
  logic          a;
  logic          s;
  logic          d;
  logic [NT-1:0] tilemap_walls;
  logic [NT-1:0] tilemap_dots;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    player_direction;
  logic          moving;
  logic          eat;
  logic [IW-1:0] eat_idx;
  logic [SCORE_W-1:0] score;

  modport master (
    output freeze, w, a, s, d, tilemap_walls, tilemap_dots,
    input  x, y, player_direction, moving, eat, eat_idx, score
  );

  modport slave (
    input  freeze, w, a, s, d, tilemap_walls, tilemap_dots,
    output x, y, player_direction, moving, eat, eat_idx, score
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Grid-aligned Pac-Man player movement: buffered turns at tile centres, instant
// reversal, optional horizontal tunnel wrap, dot-eat pulses and a saturating score.
module player_motion_ctrl #(
  parameter int TILE      = 20,
  parameter int COLS      = 32,
  parameter int ROWS      = 24,
  parameter int SPEED     = 1,
  parameter int TICK_DIV  = 1,
  parameter int START_COL = 20,
  parameter int START_ROW = 20,
  parameter int WRAP      = 1,
  parameter int SCORE_W   = 12
) (
  input  logic clk,
  input  logic reset,
  player_motion_ctrl_if.slave bus
);
  localparam int XW = $clog2(COLS * TILE);
  localparam int YW = $clog2(ROWS * TILE);
  localparam int NT = ROWS * COLS;
  localparam int IW = $clog2(NT);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MOVING  = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic               pend_vld_q, pend_vld_d;
  logic [1:0]         pend_dir_q, pend_dir_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [FW-1:0]      fx_q, fx_d;
  logic [FW-1:0]      fy_q, fy_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [DW-1:0]      div_q, div_d;
  logic               moved_q, moved_d;
  logic               eat_q, eat_d;
  logic [IW-1:0]      eat_idx_q, eat_idx_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic          key_vld;
  logic [1:0]    key_dir;
  logic          pv;
  logic [1:0]    pdir;
  logic          step;
  logic          aligned;
  logic          consume;
  logic          do_move;
  logic [IW-1:0] cur_idx;

  // Neighbour of tile (r,c) in direction dir is open: on-map (or wrapped) and no wall.
  function automatic logic nb_open(input logic [1:0] dir, input logic [RW-1:0] r,
                                   input logic [CW-1:0] c, input logic [NT-1:0] walls);
    int   nr;
    int   nc;
    logic ok;
    nr = int'(r);
    nc = int'(c);
    ok = 1'b1;
    case (dir)
      DIR_UP:   if (nr == 0) ok = 1'b0; else nr = nr - 1;
      DIR_DOWN: if (nr == ROWS - 1) ok = 1'b0; else nr = nr + 1;
      DIR_LEFT: begin
        if (nc == 0) begin
          if (WRAP != 0) nc = COLS - 1; else ok = 1'b0;
        end else nc = nc - 1;
      end
      default: begin
        if (nc == COLS - 1) begin
          if (WRAP != 0) nc = 0; else ok = 1'b0;
        end else nc = nc + 1;
      end
    endcase
    if (ok) ok = !walls[IW'(nr * COLS + nc)];
    return ok;
  endfunction

  always_comb begin
    key_vld = !(bus.w && bus.s && bus.a && bus.d);
    if (!bus.w)      key_dir = DIR_UP;
    else if (!bus.s) key_dir = DIR_DOWN;
    else if (!bus.a) key_dir = DIR_LEFT;
    else             key_dir = DIR_RIGHT;
  end

  // A key held on the step clock acts immediately; otherwise the buffered pending applies.
  assign pv      = key_vld || pend_vld_q;
  assign pdir    = key_vld ? key_dir : pend_dir_q;
  assign step    = !bus.freeze && (div_q == DW'(TICK_DIV - 1));
  assign aligned = (fx_q == '0) && (fy_q == '0);
  assign cur_idx = IW'(int'(row_q) * COLS + int'(col_q));

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    col_d      = col_q;
    row_d      = row_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    div_d      = div_q;
    moved_d    = moved_q;
    eat_d      = 1'b0;
    eat_idx_d  = eat_idx_q;
    score_d    = score_q;
    consume    = 1'b0;
    do_move    = 1'b0;

    if (!bus.freeze) begin
      div_d   = step ? '0 : div_q + DW'(1);
      moved_d = 1'b0;

      // moved_q marks that the previous step changed position, so a stationary
      // player never re-eats the tile it is sitting on.
      if (moved_q && aligned && bus.tilemap_dots[cur_idx]) begin
        eat_d     = 1'b1;
        eat_idx_d = cur_idx;
        if (score_q != '1) score_d = score_q + SCORE_W'(1);
      end

      if (step) begin
        if (aligned) begin
          if (state_q != ST_IDLE || pv) begin
            if (pv && nb_open(pdir, row_q, col_q, bus.tilemap_walls)) begin
              dir_d   = pdir;
              consume = 1'b1;
              state_d = ST_MOVING;
              do_move = 1'b1;
            end else if (nb_open(dir_q, row_q, col_q, bus.tilemap_walls)) begin
              state_d = ST_MOVING;
              do_move = 1'b1;
            end else begin
              state_d = ST_STOPPED;
            end
          end
        end else begin
          if (pv && pdir == (dir_q ^ 2'b01)) begin
            dir_d   = pdir;
            consume = 1'b1;
          end
          do_move = 1'b1;
        end
      end

      if (consume) begin
        pend_vld_d = 1'b0;
      end else if (key_vld) begin
        pend_vld_d = 1'b1;
        pend_dir_d = key_dir;
      end

      if (do_move) begin
        moved_d = 1'b1;
        case (dir_d)
          DIR_UP: begin
            if (fy_q == '0) begin
              row_d = row_q - RW'(1);
              fy_d  = FW'(TILE - SPEED);
            end else fy_d = fy_q - FW'(SPEED);
          end
          DIR_DOWN: begin
            if (int'(fy_q) + SPEED == TILE) begin
              row_d = row_q + RW'(1);
              fy_d  = '0;
            end else fy_d = fy_q + FW'(SPEED);
          end
          DIR_LEFT: begin
            if (fx_q == '0) begin
              if (col_q == '0) col_d = CW'(COLS - 1);
              else begin
                col_d = col_q - CW'(1);
                fx_d  = FW'(TILE - SPEED);
              end
            end else fx_d = fx_q - FW'(SPEED);
          end
          default: begin
            if (fx_q == '0 && int'(col_q) == COLS - 1) col_d = '0;
            else if (int'(fx_q) + SPEED == TILE) begin
              col_d = col_q + CW'(1);
              fx_d  = '0;
            end else fx_d = fx_q + FW'(SPEED);
          end
        endcase
      end
    end

    x_d = XW'(int'(col_d) * TILE + int'(fx_d));
    y_d = YW'(int'(row_d) * TILE + int'(fy_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_LEFT;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_UP;
      col_q      <= CW'(START_COL);
      row_q      <= RW'(START_ROW);
      fx_q       <= '0;
      fy_q       <= '0;
      x_q        <= XW'(START_COL * TILE);
      y_q        <= YW'(START_ROW * TILE);
      div_q      <= '0;
      moved_q    <= 1'b0;
      eat_q      <= 1'b0;
      eat_idx_q  <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      div_q      <= div_d;
      moved_q    <= moved_d;
      eat_q      <= eat_d;
      eat_idx_q  <= eat_idx_d;
      score_q    <= score_d;
    end
  end

  assign bus.x                = x_q;
  assign bus.y                = y_q;
  assign bus.player_direction = dir_q;
  assign bus.moving           = (state_q == ST_MOVING);
  assign bus.eat              = eat_q;
  assign bus.eat_idx          = eat_idx_q;
  assign bus.score            = score_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed checks of player_motion_ctrl: a full-size map instance and a tiny
// saturating-score instance with a divided step rate and no wrap.
module tb_player_motion_ctrl;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   eats;

  player_motion_ctrl_if #(.TILE(20), .COLS(32), .ROWS(24), .SCORE_W(12)) bus_a ();
  player_motion_ctrl_if #(.TILE(2),  .COLS(8),  .ROWS(2),  .SCORE_W(2))  bus_b ();

  player_motion_ctrl #(
    .TILE(20), .COLS(32), .ROWS(24), .SPEED(1), .TICK_DIV(1),
    .START_COL(20), .START_ROW(20), .WRAP(1), .SCORE_W(12)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .bus(bus_a)
  );

  player_motion_ctrl #(
    .TILE(2), .COLS(8), .ROWS(2), .SPEED(1), .TICK_DIV(2),
    .START_COL(0), .START_ROW(0), .WRAP(0), .SCORE_W(2)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    {bus_a.w, bus_a.a, bus_a.s, bus_a.d} = 4'hF;
    {bus_b.w, bus_b.a, bus_b.s, bus_b.d} = 4'hF;
    bus_a.freeze = 1'b0;
    bus_b.freeze = 1'b0;
    bus_a.tilemap_walls = '0;
    bus_a.tilemap_dots  = '0;
    bus_b.tilemap_walls = '0;
    bus_b.tilemap_dots  = '0;
    tick(1);
    do_reset();

    check("rst_x", bus_a.x, 400);
    check("rst_y", bus_a.y, 400);
    check("rst_dir", bus_a.player_direction, 2);
    check("rst_score", bus_a.score, 0);
    check("rst_moving", bus_a.moving, 0);
    check("rst_eat", bus_a.eat, 0);

    // Start right, buffer an up-turn mid-tile, taken at x=420.
    bus_a.d = 1'b0;
    tick(1);
    bus_a.d = 1'b1;
    check("start_x", bus_a.x, 401);
    check("start_dir", bus_a.player_direction, 3);
    check("start_moving", bus_a.moving, 1);
    tick(4);
    check("x405", bus_a.x, 405);
    bus_a.w = 1'b0;
    tick(1);
    bus_a.w = 1'b1;
    check("buf_noturn_dir", bus_a.player_direction, 3);
    check("buf_noturn_x", bus_a.x, 406);
    tick(14);
    check("centre_x", bus_a.x, 420);
    check("centre_dir", bus_a.player_direction, 3);
    tick(1);
    check("turn_dir", bus_a.player_direction, 0);
    check("turn_y", bus_a.y, 399);
    check("turn_x", bus_a.x, 420);

    bus_a.freeze = 1'b1;
    tick(3);
    check("frz_y", bus_a.y, 399);
    check("frz_moving", bus_a.moving, 1);
    bus_a.freeze = 1'b0;
    tick(1);
    check("unfrz_y", bus_a.y, 398);

    // Async reset mid-move takes effect before any clock edge.
    rst_n = 1'b0;
    #1;
    check("async_rst_x", bus_a.x, 400);
    check("async_rst_y", bus_a.y, 400);
    check("async_rst_moving", bus_a.moving, 0);
    tick(1);
    rst_n = 1'b1;

    // Instant reversal while unaligned.
    bus_a.d = 1'b0;
    tick(1);
    bus_a.d = 1'b1;
    tick(4);
    bus_a.a = 1'b0;
    tick(1);
    bus_a.a = 1'b1;
    check("rev_dir", bus_a.player_direction, 2);
    check("rev_x", bus_a.x, 404);
    tick(5);
    check("rev_pass_x", bus_a.x, 399);
    check("rev_pass_moving", bus_a.moving, 1);

    // Wall ahead at (20,22): stop at x=420, resume when cleared.
    do_reset();
    bus_a.tilemap_walls[662] = 1'b1;
    bus_a.d = 1'b0;
    tick(1);
    bus_a.d = 1'b1;
    tick(19);
    check("wall_arrive_x", bus_a.x, 420);
    tick(1);
    check("wall_stop_x", bus_a.x, 420);
    check("wall_stop_moving", bus_a.moving, 0);
    tick(1);
    check("wall_hold_x", bus_a.x, 420);
    bus_a.tilemap_walls[662] = 1'b0;
    tick(1);
    check("wall_resume_x", bus_a.x, 421);
    check("wall_resume_moving", bus_a.moving, 1);

    // Tunnel wrap from x=0 to x=620 and eat the dot at (20,31).
    do_reset();
    bus_a.tilemap_dots[671] = 1'b1;
    bus_a.a = 1'b0;
    tick(1);
    bus_a.a = 1'b1;
    check("left_x", bus_a.x, 399);
    tick(399);
    check("edge_x", bus_a.x, 0);
    tick(1);
    check("wrap_x", bus_a.x, 620);
    check("wrap_eat", bus_a.eat, 0);
    tick(1);
    check("eat_pulse", bus_a.eat, 1);
    check("eat_idx", bus_a.eat_idx, 671);
    check("eat_score", bus_a.score, 1);
    check("eat_x", bus_a.x, 619);
    tick(1);
    check("eat_end", bus_a.eat, 0);
    check("eat_score_hold", bus_a.score, 1);

    // Small map: divided steps, 7 eats saturate a 2-bit score, edge acts as wall.
    do_reset();
    bus_b.tilemap_dots = 16'h00FF;
    bus_b.d = 1'b0;
    tick(1);
    bus_b.d = 1'b1;
    check("b_nostep_x", bus_b.x, 0);
    tick(1);
    check("b_step1_x", bus_b.x, 1);
    tick(1);
    check("b_hold_x", bus_b.x, 1);
    tick(1);
    check("b_land_x", bus_b.x, 2);
    check("b_land_eat", bus_b.eat, 0);
    tick(1);
    check("b_eat", bus_b.eat, 1);
    check("b_eat_idx", bus_b.eat_idx, 1);
    check("b_score1", bus_b.score, 1);
    eats = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (bus_b.eat) eats++;
    end
    check("b_eats", eats, 6);
    check("b_score_sat", bus_b.score, 3);
    check("b_end_x", bus_b.x, 14);
    check("b_end_moving", bus_b.moving, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
